// File: rtl/dmem_handshake_bridge.sv
// Data-side memory bridge: turns the M-stage load/store request into a single
// sram-like bus transaction, stalls the pipeline until it completes, holds the
// result across unrelated stalls and drains transactions cancelled by a flush.
module dmem_handshake_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_wdata,
  input  logic              except_i,
  input  logic              flush_i,
  input  logic              pipe_stall,
  output logic [31:0]       mem_rdata,
  output logic              stallreq_from_mem,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] reqAddr;
  logic              reqWr;
  logic [1:0]        reqSize;
  logic [3:0]        reqStrb;
  logic [31:0]       reqWdata;
  logic [31:0]       rdataQ;
  logic              flushSeen;
  logic              flushSeenNext;
  logic              go;
  logic              issueNow;
  logic              cancelled;

  // Reset is folded in so nothing is requested while the bus is held in reset.
  assign go        = rst & mem_en & ~except_i & ~flush_i;
  assign cancelled = flushSeen | flush_i;

  // Next-state, handshake and stall decode; stall never looks at pipe_stall.
  always_comb begin
    stateNext         = state;
    flushSeenNext     = flushSeen;
    issueNow          = 1'b0;
    data_req          = 1'b0;
    stallreq_from_mem = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          issueNow          = 1'b1;
          data_req          = 1'b1;
          stallreq_from_mem = 1'b1;
          flushSeenNext     = 1'b0;
          stateNext         = data_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        data_req          = 1'b1;
        stallreq_from_mem = go | cancelled;
        if (data_addr_ok) begin
          stateNext     = cancelled ? DRAIN : DATA;
          flushSeenNext = 1'b0;
        end else if (flush_i) begin
          flushSeenNext = 1'b1;
        end
      end
      DATA: begin
        if (data_data_ok) begin
          stateNext = (pipe_stall && !flush_i) ? DONE : IDLE;
        end else begin
          stallreq_from_mem = go;
          if (flush_i) stateNext = DRAIN;
        end
      end
      DONE: begin
        if (!pipe_stall || flush_i) stateNext = IDLE;
      end
      DRAIN: begin
        stallreq_from_mem = 1'b1;
        if (data_data_ok) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request fields: live inputs in the issue cycle, latched copy while waiting
  // for acceptance, zero whenever no request is on the bus.
  always_comb begin
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wstrb = 4'd0;
    data_wdata = 32'd0;
    if (issueNow) begin
      data_wr    = mem_wen;
      data_size  = mem_size;
      data_addr  = mem_addr;
      data_wstrb = mem_wen ? mem_sel : 4'd0;
      data_wdata = mem_wdata;
    end else if (state == ADDR) begin
      data_wr    = reqWr;
      data_size  = reqSize;
      data_addr  = reqAddr;
      data_wstrb = reqStrb;
      data_wdata = reqWdata;
    end
  end

  // Read data bypasses straight from the bus in the completion cycle.
  assign mem_rdata = (state == DATA && data_data_ok) ? data_rdata : rdataQ;

  // State register and flush-seen flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flushSeen <= 1'b0;
    end else begin
      state     <= stateNext;
      flushSeen <= flushSeenNext;
    end
  end

  // Request registers capture the access at issue and hold it until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqAddr  <= '0;
      reqWr    <= 1'b0;
      reqSize  <= 2'd0;
      reqStrb  <= 4'd0;
      reqWdata <= 32'd0;
    end else if (issueNow) begin
      reqAddr  <= mem_addr;
      reqWr    <= mem_wen;
      reqSize  <= mem_size;
      reqStrb  <= mem_wen ? mem_sel : 4'd0;
      reqWdata <= mem_wdata;
    end
  end

  // Result register loads on completion of a live (non-drained) transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdataQ <= 32'd0;
    end else if (state == DATA && data_data_ok) begin
      rdataQ <= data_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_handshake_bridge.sv
// Directed bench for dmem_handshake_bridge: inputs change 1ns after the rising
// edge, outputs are compared at the falling edge against hand-computed values.
module tb_dmem_handshake_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en, mem_wen, except_i, flush_i, pipe_stall;
  logic [31:0] mem_addr, mem_wdata, data_rdata;
  logic [3:0]  mem_sel;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata, data_addr, data_wdata;
  logic        stallreq_from_mem, data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int nVec  = 0;
  int nMiss = 0;

  always #5 clk = ~clk;

  dmem_handshake_bridge #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_size(mem_size), .mem_wdata(mem_wdata),
    .except_i(except_i), .flush_i(flush_i), .pipe_stall(pipe_stall),
    .mem_rdata(mem_rdata), .stallreq_from_mem(stallreq_from_mem),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clearInputs();
    mem_en = 0; mem_wen = 0; mem_addr = 0; mem_sel = 0; mem_size = 0;
    mem_wdata = 0; except_i = 0; flush_i = 0; pipe_stall = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic aok);
    mem_en = 1; mem_wen = 0; mem_addr = a; mem_size = 2'd2; mem_sel = 4'hF;
    data_addr_ok = aok; data_data_ok = 0;
  endtask

  task automatic chkHs(input string tag, input logic req, input logic stall);
    chk({tag, ".req"}, {31'd0, data_req}, {31'd0, req});
    chk({tag, ".stall"}, {31'd0, stallreq_from_mem}, {31'd0, stall});
  endtask

  initial begin
    clearInputs();
    #2 rst = 0;
    settle();
    // reset state
    chkHs("rst", 0, 0);
    chk("rst.addr", data_addr, 0);
    chk("rst.rdata", mem_rdata, 0);
    adv();
    rst = 1;
    adv();

    // best-case load
    load(32'h1000, 1); settle();
    chkHs("ld1.issue", 1, 1);
    chk("ld1.addr", data_addr, 32'h1000);
    chk("ld1.size", {30'd0, data_size}, 2);
    chk("ld1.wr", {31'd0, data_wr}, 0);
    chk("ld1.wstrb", {28'd0, data_wstrb}, 0);
    adv();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h12345678; settle();
    chkHs("ld1.dok", 0, 0);
    chk("ld1.bypass", mem_rdata, 32'h12345678);
    adv();
    clearInputs(); settle();
    chkHs("ld1.after", 0, 0);
    chk("ld1.hold", mem_rdata, 32'h12345678);
    adv();

    // store byte, addr_ok delayed 3 cycles; live inputs scrambled after issue
    mem_en = 1; mem_wen = 1; mem_addr = 32'h80000003; mem_sel = 4'b1000;
    mem_size = 2'd0; mem_wdata = 32'hAB000000; settle();
    chkHs("sb.c0", 1, 1);
    chk("sb.c0.addr", data_addr, 32'h80000003);
    chk("sb.c0.strb", {28'd0, data_wstrb}, 4'b1000);
    chk("sb.c0.wdata", data_wdata, 32'hAB000000);
    chk("sb.c0.wr", {31'd0, data_wr}, 1);
    adv();
    mem_addr = 32'h11111110; mem_sel = 4'b0001; mem_wdata = 32'h000000CD;
    for (int i = 1; i <= 3; i++) begin
      data_addr_ok = (i == 3); settle();
      chkHs($sformatf("sb.c%0d", i), 1, 1);
      chk($sformatf("sb.c%0d.addr", i), data_addr, 32'h80000003);
      chk($sformatf("sb.c%0d.strb", i), {28'd0, data_wstrb}, 4'b1000);
      chk($sformatf("sb.c%0d.wdata", i), data_wdata, 32'hAB000000);
      chk($sformatf("sb.c%0d.wr", i), {31'd0, data_wr}, 1);
      adv();
    end
    data_addr_ok = 0; settle();
    chkHs("sb.wait", 0, 1);
    adv();
    data_data_ok = 1; data_rdata = 32'h0; settle();
    chkHs("sb.dok", 0, 0);
    adv();
    clearInputs();

    // load completes under pipe_stall -> DONE holds the result
    load(32'h0000_2004, 1); settle();
    chkHs("dn.issue", 1, 1);
    adv();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFEF00D; pipe_stall = 1; settle();
    chkHs("dn.dok", 0, 0);
    chk("dn.bypass", mem_rdata, 32'hCAFEF00D);
    adv();
    data_data_ok = 0; data_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chkHs($sformatf("dn.hold%0d", i), 0, 0);
      chk($sformatf("dn.hold%0d.rdata", i), mem_rdata, 32'hCAFEF00D);
      adv();
    end
    pipe_stall = 0; settle();
    chkHs("dn.release", 0, 0);
    adv();
    load(32'h0000_2008, 1); settle();
    chkHs("dn.reissue", 1, 1);
    chk("dn.reissue.addr", data_addr, 32'h2008);
    adv();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BADBEEF; settle();
    chk("dn.ld2", mem_rdata, 32'h0BADBEEF);
    adv();
    clearInputs();

    // flush during DATA -> drain, then the new load issues
    load(32'h3000, 1); settle();
    adv();
    data_addr_ok = 0; flush_i = 1; settle();
    chkHs("fl.flush", 0, 0);
    adv();
    flush_i = 0; load(32'h4000, 0); settle();
    chkHs("fl.drain", 0, 1);
    adv();
    data_data_ok = 1; data_rdata = 32'hDEAD0001; settle();
    chkHs("fl.drainok", 0, 1);
    chk("fl.discard", mem_rdata, 32'h0BADBEEF);
    adv();
    data_data_ok = 0; data_rdata = 0; data_addr_ok = 1; settle();
    chkHs("fl.newissue", 1, 1);
    chk("fl.newaddr", data_addr, 32'h4000);
    adv();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h600D0002; settle();
    chk("fl.second", mem_rdata, 32'h600D0002);
    adv();
    clearInputs(); settle();
    chk("fl.hold", mem_rdata, 32'h600D0002);
    adv();

    // exception and flush in IDLE suppress issue
    load(32'h5000, 1); except_i = 1; settle();
    chkHs("ex", 0, 0);
    adv();
    except_i = 0; flush_i = 1; settle();
    chkHs("flidle", 0, 0);
    adv();
    clearInputs();

    // flush seen while waiting for addr_ok -> drained after acceptance
    load(32'h6000, 0); settle();
    chkHs("fa.issue", 1, 1);
    adv();
    flush_i = 1; settle();
    chkHs("fa.flush", 1, 1);
    adv();
    clearInputs(); data_addr_ok = 1; settle();
    chkHs("fa.accept", 1, 1);
    chk("fa.addr", data_addr, 32'h6000);
    adv();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h00000099; settle();
    chkHs("fa.drain", 0, 1);
    chk("fa.discard", mem_rdata, 32'h600D0002);
    adv();
    clearInputs();

    // asynchronous reset while in ADDR
    load(32'h7000, 0); mem_wdata = 32'h5555AAAA; settle();
    adv();
    settle();
    chkHs("ra.addr", 1, 1);
    rst = 0; #1;
    chkHs("ra.inrst", 0, 0);
    chk("ra.inrst.addr", data_addr, 0);
    chk("ra.inrst.rdata", mem_rdata, 0);
    adv();
    rst = 1; clearInputs(); settle();
    chkHs("ra.post", 0, 0);
    chk("ra.post.addr", data_addr, 0);
    adv();
    load(32'h7004, 1); settle();
    chkHs("ra.idle", 1, 1);
    adv();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h00000007; settle();
    chk("ra.ld", mem_rdata, 32'h7);
    adv();

    // spurious data_ok in IDLE is ignored
    clearInputs(); data_data_ok = 1; data_rdata = 32'hFFFFFFFF; settle();
    chkHs("sp", 0, 0);
    chk("sp.rdata", mem_rdata, 32'h7);
    adv();
    data_data_ok = 0; settle();
    chk("sp.hold", mem_rdata, 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/dmem_handshake_bridge.md
# dmem_handshake_bridge

Memory-stage data-side bridge, sitting between the pipeline's M-stage memory request (enable, write, address, byte select, size, store data) and the data cache's sram-like request/response handshake. It issues each memory access once, drives `stallreq_from_mem` until the response arrives, and returns the raw read word. It holds a finished result while the pipeline is stalled for other reasons, and drains cancelled accesses after a flush so that bus transactions are never abandoned.

## Interface
- `ADDR_W`, 32, address width on both sides.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_en` in 1: M-stage load/store valid.
- `mem_wen` in 1: access is a store.
- `mem_addr` in ADDR_W: byte address.
- `mem_sel` in 4: store byte enables.
- `mem_size` in 2: access size; 0 = byte, 1 = half, 2 = word.
- `mem_wdata` in 32: aligned store data.
- `except_i` in 1: M-stage exception pending (address error, TLB, etc.); suppresses issue.
- `flush_i` in 1: M-stage flush.
- `pipe_stall` in 1: M stage held this cycle by any other cause.
- `mem_rdata` out 32: raw load word.
- `stallreq_from_mem` out 1: hold pipeline.
- `data_req` out 1: request valid.
- `data_wr` out 1: write request.
- `data_size` out 2: access size.
- `data_addr` out ADDR_W: request address.
- `data_wstrb` out 4: byte strobes.
- `data_wdata` out 32: write data.
- `data_addr_ok` in 1: request accepted.
- `data_data_ok` in 1: response or write-complete.
- `data_rdata` in 32: response data.

## Operation
- States:
  - IDLE: no outstanding transaction.
  - ADDR: request presented, not yet accepted.
  - DATA: request accepted, response pending.
  - DONE: result held while the pipeline is stalled.
  - DRAIN: cancelled transaction whose response must be swallowed.
- `go = mem_en & ~except_i & ~flush_i`.
- IDLE with `go`:
  - Assert `data_req` combinationally from the live inputs, so there is no issue bubble.
  - Latch addr, wr, size, wstrb and wdata into request registers.
  - Next state is DATA if `data_addr_ok`, otherwise ADDR.
- ADDR:
  - `data_req` = 1, driven from the latched registers, which stay stable until accepted.
  - On `data_addr_ok`: next state is DRAIN if a flush was seen while in ADDR or this cycle, otherwise DATA.
- DATA on `data_data_ok`:
  - Capture `data_rdata` into `rdata_q`.
  - Next state is DONE if `pipe_stall`, otherwise IDLE.
  - If `flush_i` is high in the same cycle, go to IDLE.
- DATA with `flush_i` and no `data_data_ok`: go to DRAIN.
- DONE:
  - `stallreq_from_mem` = 0 and `mem_rdata` = `rdata_q`.
  - Leave for IDLE when `~pipe_stall | flush_i`.
  - Never reissue.
- DRAIN: on `data_data_ok`, discard the data and go to IDLE.
- `stallreq_from_mem` is 1 when either:
  - `go` is high and the state is IDLE, ADDR, or DATA without `data_data_ok`; or
  - the state is DRAIN, or ADDR with a cancelled request (the new instruction must not issue until the bus is free).
- `stallreq_from_mem` never depends on `pipe_stall`, so there is no combinational loop.
- `mem_rdata`:
  - `rdata_q` in DONE.
  - `data_rdata` in DATA while `data_data_ok` is high (bypass).
  - `rdata_q` otherwise.
- `data_wstrb` = `mem_sel` for stores, 0 for loads.
- `data_wdata` and `data_addr` pass through unmodified; byte extraction happens downstream.
- Reset: state IDLE, request registers 0, `rdata_q` 0, flush-seen flag 0.
  - With `mem_en` = 0 every output is 0.
  - Reset mid-transaction abandons it; the cache is reset by the same `rst`.

## Timing
- Best case (addr_ok in the issue cycle, data_ok in the next cycle): `stallreq_from_mem` is high for exactly 1 cycle; the load word is valid on `mem_rdata` in the data_ok cycle.
- Each extra cycle of addr_ok or data_ok delay adds one stall cycle.
- At most one outstanding transaction; `data_req` is never asserted in DATA, DONE, or DRAIN.
- A new request may issue in the cycle after IDLE is re-entered, never in the same cycle as `data_data_ok`.
- `except_i` or `flush_i` in IDLE: no request, no stall.
- `data_data_ok` without an outstanding transaction is ignored.

## Test plan
- Load, addr_ok same cycle, data_ok next cycle with `data_rdata` = 0x12345678 -> `data_req` high 1 cycle, `stallreq_from_mem` high 1 cycle, `mem_rdata` = 0x12345678.
- Store sb: `mem_addr` = 0x80000003, `mem_sel` = 4'b1000, `mem_wdata` = 0xAB000000; addr_ok delayed 3 cycles -> `data_req` held 4 cycles with stable addr/strobe/data, `data_wr` = 1, stall until data_ok.
- Load completes while `pipe_stall` = 1 for 4 cycles -> DONE; `mem_rdata` holds the value, `data_req` stays 0, IDLE after `pipe_stall` falls.
- `flush_i` pulse in DATA, then a new load presented -> DRAIN; the first data_ok is discarded, the new load issues the cycle after, and `mem_rdata` equals the second response.
- `except_i` = 1 with `mem_en` = 1 -> no `data_req`, `stallreq_from_mem` = 0.
- `rst` low while in ADDR -> all outputs 0 immediately; IDLE after release.
